// File: rtl/line_memory_if.sv
// Request/response bundle between a cache miss/writeback port and line_memory.
// Latency: none (wires only).
// Backpressure: the master holds mem_req_valid_i until it sees mem_req_ready_o high.
//
// Signals:
//   mem_req_valid_i / mem_req_ready_o : request handshake
//   mem_req_rw_i                      : 1 = write, 0 = read
//   mem_req_addr_i                    : byte address
//   mem_req_data_i / mem_req_wmask_i  : write line (word 0 in LSBs), per-word enables
//   mem_resp_valid_o                  : one-cycle response pulse
//   mem_resp_data_o / mem_resp_err_o  : read line, out-of-range flag
interface line_memory_if #(
  parameter int ADDR_W     = 32,
  parameter int WORD_W     = 32,
  parameter int LINE_WORDS = 4
);
  logic                         mem_req_valid_i;
  logic                         mem_req_ready_o;
  logic                         mem_req_rw_i;
  logic [ADDR_W-1:0]            mem_req_addr_i;
  logic [LINE_WORDS*WORD_W-1:0] mem_req_data_i;
  logic [LINE_WORDS-1:0]        mem_req_wmask_i;
  logic                         mem_resp_valid_o;
  logic [LINE_WORDS*WORD_W-1:0] mem_resp_data_o;
  logic                         mem_resp_err_o;

  modport master (
    output mem_req_valid_i, mem_req_rw_i, mem_req_addr_i, mem_req_data_i, mem_req_wmask_i,
    input  mem_req_ready_o, mem_resp_valid_o, mem_resp_data_o, mem_resp_err_o
  );

  modport slave (
    input  mem_req_valid_i, mem_req_rw_i, mem_req_addr_i, mem_req_data_i, mem_req_wmask_i,
    output mem_req_ready_o, mem_resp_valid_o, mem_resp_data_o, mem_resp_err_o
  );
endinterface

// File: rtl/line_memory.sv
// Line-granular backing memory with a programmable access latency.
// Latency: response pulse exactly LATENCY cycles after request acceptance.
// Backpressure: one request outstanding; ready is low from acceptance until the
//               cycle after the response pulse, and low while rst is high.
//
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : line_memory_if slave (request handshake + response pulse)
module line_memory #(
  parameter int ADDR_W      = 32,
  parameter int WORD_W      = 32,
  parameter int LINE_WORDS  = 4,
  parameter int DEPTH_WORDS = 8192,
  parameter int LATENCY     = 4
) (
  input  logic          clk,
  input  logic          rst,
  line_memory_if.slave  bus
);

  localparam int LINE_W = LINE_WORDS * WORD_W;
  localparam int OFF_W  = $clog2(WORD_W / 8);
  localparam int ARR_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  // Counter only ever holds LATENCY-1 down to 0.
  localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                rw_q, rw_d;
  logic [ARR_AW-1:0]   base_q, base_d;
  logic                oor_q, oor_d;
  logic [LINE_W-1:0]   data_q, data_d;
  logic [LINE_WORDS-1:0] wmask_q, wmask_d;
  logic                resp_valid_q, resp_valid_d;
  logic [LINE_W-1:0]   resp_data_q, resp_data_d;
  logic                resp_err_q, resp_err_d;

  logic [WORD_W-1:0]   mem [DEPTH_WORDS];

  logic [ADDR_W-1:0]   req_word_idx;
  logic [ADDR_W-1:0]   req_base;
  logic                req_oor;
  logic                accept;
  logic                enter_resp;

  // Word index with the in-line word bits cleared, so a line never wraps.
  // The range check is done one bit wider so base+LINE_WORDS cannot overflow.
  always_comb begin
    req_word_idx = bus.mem_req_addr_i >> OFF_W;
    req_base     = req_word_idx & ~ADDR_W'(LINE_WORDS - 1);
    req_oor      = ({1'b0, req_base} + (ADDR_W+1)'(LINE_WORDS)) > (ADDR_W+1)'(DEPTH_WORDS);
  end

  assign bus.mem_req_ready_o = (state_q == IDLE) && !rst;
  assign accept              = bus.mem_req_valid_i && bus.mem_req_ready_o;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    base_d  = base_q;
    oor_d   = oor_q;
    data_d  = data_q;
    wmask_d = wmask_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          rw_d    = bus.mem_req_rw_i;
          base_d  = req_base[ARR_AW-1:0];
          oor_d   = req_oor;
          data_d  = bus.mem_req_data_i;
          wmask_d = bus.mem_req_wmask_i;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The array is accessed on the edge entering RESP. The *_d request fields are
  // used rather than *_q so that a LATENCY==1 build, which enters RESP on the
  // acceptance edge itself, sees the incoming request; otherwise they equal *_q.
  always_comb begin
    enter_resp   = (state_d == RESP) && (state_q != RESP);
    resp_valid_d = (state_d == RESP);
    resp_err_d   = enter_resp && oor_d;
    resp_data_d  = '0;
    if (enter_resp && !rw_d && !oor_d) begin
      for (int i = 0; i < LINE_WORDS; i++) begin
        resp_data_d[i*WORD_W +: WORD_W] = mem[base_d | ARR_AW'(i)];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      rw_q         <= 1'b0;
      base_q       <= '0;
      oor_q        <= 1'b0;
      data_q       <= '0;
      wmask_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rw_q         <= rw_d;
      base_q       <= base_d;
      oor_q        <= oor_d;
      data_q       <= data_d;
      wmask_q      <= wmask_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Array contents survive reset; a write still pending when rst arrives is dropped.
  always_ff @(posedge clk) begin
    if (!rst && enter_resp && rw_d && !oor_d) begin
      for (int i = 0; i < LINE_WORDS; i++) begin
        if (wmask_d[i]) mem[base_d | ARR_AW'(i)] <= data_d[i*WORD_W +: WORD_W];
      end
    end
  end

  assign bus.mem_resp_valid_o = resp_valid_q;
  assign bus.mem_resp_data_o  = resp_data_q;
  assign bus.mem_resp_err_o   = resp_err_q;

endmodule

// File: doc/line_memory.md
Name: line_memory

Overview:
Parametrised, latency-modelling backing memory for cache verification and simulation. Serves whole cache lines of LINE_WORDS words through a valid/ready request channel and a one-cycle response pulse. Sits behind the cache miss/writeback port. Adds the following:
- programmable access latency
- per-word write mask
- line alignment
- out-of-range error reporting
- a single-outstanding-request handshake

Parameters:
ADDR_W, 32, byte address width
WORD_W, 32, word width in bits; multiple of 8
LINE_WORDS, 4, words per line; power of two, >=1
DEPTH_WORDS, 8192, array size in words; multiple of LINE_WORDS
LATENCY, 4, cycles from request acceptance to response; >=1

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
mem_req_valid_i  in  1  request present
mem_req_ready_o  out  1  block can accept a request
mem_req_rw_i  in  1  1=write, 0=read
mem_req_addr_i  in  ADDR_W  byte address
mem_req_data_i  in  LINE_WORDS*WORD_W  write line; word 0 in LSBs
mem_req_wmask_i  in  LINE_WORDS  per-word write enable
mem_resp_valid_o  out  1  response pulse
mem_resp_data_o  out  LINE_WORDS*WORD_W  read line; word 0 in LSBs
mem_resp_err_o  out  1  address out of range; qualified by resp_valid

Behaviour:
- Reset values:
  - ready=0 during the rst cycle, 1 on the first cycle after rst deasserts.
  - resp_valid=0, resp_data=0, resp_err=0.
  - State is IDLE and the counter is 0.
  - Array contents are not reset.
- Word index = addr[ADDR_W-1 : log2(WORD_W/8)], with the low log2(LINE_WORDS) bits forced to 0. Byte and word offsets within a line are ignored. The line never wraps across a line boundary.
- Range check: line base index + LINE_WORDS > DEPTH_WORDS gives err=1. For an err response:
  - no array write
  - resp_data=0
  - still exactly LATENCY cycles
- FSM has three states: IDLE, WAIT, RESP.
  - IDLE: ready=1. valid&&ready at edge T means the request is accepted. Latch rw, index, data, wmask and the range flag; cnt=LATENCY-1. Next state is RESP if LATENCY==1, otherwise WAIT.
  - WAIT: ready=0. Decrement cnt on each edge. When cnt reaches 1, go to RESP on that edge.
  - RESP: ready=0. resp_valid=1 for exactly this one cycle, which is cycle T+LATENCY. The next edge returns to IDLE. The earliest next acceptance is at edge T+LATENCY+1.
- Array access occurs on the edge entering RESP, using the latched fields:
  - Write: only words with wmask[i]=1 are updated; other words are unchanged. resp_data=0.
  - Read: resp_data is the line contents at that edge.
- resp_data and resp_err hold their values only while resp_valid=1. They return to 0 on the edge leaving RESP.
- Signals other than valid are ignored while ready=0. Only one request is outstanding at a time; there is no queueing.
- Write mask of all zeros is a legal write. It produces no change and a normal response.
- Reset mid-operation:
  - State returns to IDLE and no response is issued.
  - A write not yet committed, i.e. reset before the edge entering RESP, is dropped.
  - A write already committed remains.
- rst and valid asserted together: reset wins and the request is not accepted.

Test Plan:
- Write then read, LATENCY=4. Write line 0x44444444_33333333_22222222_11111111 at addr 0x100 with wmask=4'hF, accepted at T. Required: resp_valid only at T+4, err=0, ready low T+1..T+4. A read at 0x100 then returns the same line.
- Masked write and alignment. Write 0xDDDD..._AAAA... at 0x100 with wmask=4'b0101. A read at addr 0x10C returns word0=new, word1=old, word2=new, word3=old.
- Out of range, default depth. Read at 0x8000 (index 8192) gives err=1 and data=0 at T+4. A write at 0x7FF0 succeeds. A write at 0x8000 leaves the array unchanged.
- Back-to-back with valid held high. The second request is accepted at T+5 and its response arrives at T+9. Requests presented during WAIT are not accepted.
- LATENCY=1 build. Accept at T gives the response at T+1, and the next acceptance is at T+2.
- Reset at T+2 during a pending write. No response is issued and ready=1 after reset. A read of that line returns the pre-write data.
